// File: rtl/msrv32_store_unit_if.sv
// Data-memory write bus between the store unit (master) and data memory (slave).
interface msrv32_store_unit_if #(
    parameter int WIDTH = 32
);
    logic             ms_riscv32_mp_dmwr_req_out;
    logic [WIDTH-1:0] ms_riscv32_mp_dmaddr_out;
    logic [WIDTH-1:0] ms_riscv32_mp_dmdata_out;
    logic [3:0]       ms_riscv32_mp_dmwr_mask_out;
    logic             ms_riscv32_mp_dmwr_ack_in;

    modport master (
        output ms_riscv32_mp_dmwr_req_out,
        output ms_riscv32_mp_dmaddr_out,
        output ms_riscv32_mp_dmdata_out,
        output ms_riscv32_mp_dmwr_mask_out,
        input  ms_riscv32_mp_dmwr_ack_in
    );

    modport slave (
        input  ms_riscv32_mp_dmwr_req_out,
        input  ms_riscv32_mp_dmaddr_out,
        input  ms_riscv32_mp_dmdata_out,
        input  ms_riscv32_mp_dmwr_mask_out,
        output ms_riscv32_mp_dmwr_ack_in
    );
endinterface

// File: rtl/msrv32_store_unit.sv
// Store unit: aligns rs2 into byte lanes, builds the write mask and runs one
// req/ack write to data memory per accepted store, stalling the pipeline while
// the write is outstanding. Misaligned stores and ack timeouts are flagged.
module msrv32_store_unit #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_in,
    input  logic                store_req_in,
    input  logic [1:0]          store_size_in,
    input  logic [WIDTH-1:0]    iadder_in,
    input  logic [WIDTH-1:0]    rs2_in,
    msrv32_store_unit_if.master dm,
    output logic                store_stall_out,
    output logic                store_done_out,
    output logic                misaligned_store_out,
    output logic                store_fault_out
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [3:0]       mask_q, mask_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             mis_q, mis_d;

    // Lane alignment of the presented store
    logic [WIDTH-1:0] al_data;
    logic [3:0]       al_mask;
    logic             al_mis;
    logic [1:0]       a;

    assign a = iadder_in[1:0];

    // Replicate the source bytes into every lane and pick the lanes to enable
    always_comb begin
        al_data = rs2_in;
        al_mask = 4'b1111;
        al_mis  = 1'b0;
        case (store_size_in)
            2'b00: begin
                al_data = {4{rs2_in[7:0]}};
                al_mask = 4'b0001 << a;
                al_mis  = 1'b0;
            end
            2'b01: begin
                al_data = {2{rs2_in[15:0]}};
                al_mask = a[1] ? 4'b1100 : 4'b0011;
                al_mis  = a[0];
            end
            default: begin
                // 2'b11 is treated as a word store
                al_data = rs2_in;
                al_mask = 4'b1111;
                al_mis  = |a;
            end
        endcase
    end

    // Next-state and registered-output logic of the write FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (store_req_in) begin
                    if (al_mis) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d  = {iadder_in[WIDTH-1:2], 2'b00};
                        data_d  = al_data;
                        mask_d  = al_mask;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // An ack in the final timeout cycle still completes the write
                if (dm.ms_riscv32_mp_dmwr_ack_in) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight write
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            mis_q   <= mis_d;
        end
    end

    assign dm.ms_riscv32_mp_dmwr_req_out  = (state_q == BUSY);
    assign dm.ms_riscv32_mp_dmaddr_out    = addr_q;
    assign dm.ms_riscv32_mp_dmdata_out    = data_q;
    assign dm.ms_riscv32_mp_dmwr_mask_out = mask_q;

    // Pipeline is released in the ack cycle so the held store retires once
    assign store_stall_out      = (state_q == BUSY) & ~dm.ms_riscv32_mp_dmwr_ack_in;
    assign store_done_out       = done_q;
    assign store_fault_out      = fault_q;
    assign misaligned_store_out = mis_q;
endmodule
